// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter and sequencer for an external 8:1 word mux with a registered output stage.
// Optional build macro MUX8_ARB_HIPRI_PORT0_EN gives port 0 absolute priority at every load.
module mux8_rr_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            req,
  output logic [7:0]            ack,
  output logic                  mux_sel_2,
  output logic                  mux_sel_1,
  output logic                  mux_sel_0,
  input  logic [DATA_WIDTH-1:0] mux_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [2:0]            out_port
);

  localparam logic [3:0] BURST_MAX = 4'(BURST_LEN);

  logic [2:0]            last_grant_r;
  logic [3:0]            burst_cnt_r;
  logic                  out_valid_r;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic [2:0]            out_port_r;

  logic                  slot_free_s;
  logic                  any_req_s;
  logic                  cont_s;
  logic                  hipri_s;
  logic                  load_s;
  logic                  grant_en_s;
  logic [2:0]            chosen_s;
  logic [2:0]            sel_s;

  // Nearest requester above 'last' wins; 'last' itself is scanned last, so it has lowest priority.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] last);
    logic [2:0] idx;
    rr_pick = last;
    for (int i = 8; i >= 1; i--) begin
      idx     = last + 3'(i);
      rr_pick = r[idx] ? idx : rr_pick;
    end
  endfunction

  // Requester choice, load decision, ack and mux select.
  always_comb begin
    slot_free_s = !out_valid_r || out_ready;
    any_req_s   = |req;
    cont_s      = (burst_cnt_r != 4'd0) && (burst_cnt_r < BURST_MAX) && req[out_port_r];
    hipri_s     = 1'b0;
    chosen_s    = last_grant_r;
`ifdef MUX8_ARB_HIPRI_PORT0_EN
    if (req[0]) begin
      hipri_s  = 1'b1;
      chosen_s = 3'd0;
    end else if (cont_s) begin
      chosen_s = out_port_r;
    end else begin
      chosen_s = rr_pick(req, last_grant_r);
    end
`else
    if (cont_s) begin
      chosen_s = out_port_r;
    end else begin
      chosen_s = rr_pick(req, last_grant_r);
    end
`endif
    load_s     = slot_free_s && any_req_s;
    // Reset only gates the combinational handshake; the flops are already held by the async clear.
    grant_en_s = load_s && rst_n;
    if (grant_en_s) begin
      ack   = 8'd1 << chosen_s;
      sel_s = chosen_s;
    end else begin
      ack   = 8'd0;
      sel_s = last_grant_r;
    end
  end

  // Output register, tenure counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_r <= 3'd7;
      burst_cnt_r  <= 4'd0;
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_port_r   <= 3'd0;
    end else if (load_s) begin
      out_data_r  <= mux_out;
      out_port_r  <= chosen_s;
      out_valid_r <= 1'b1;
      if (hipri_s) begin
        burst_cnt_r <= 4'd0;
      end else if (cont_s) begin
        burst_cnt_r <= burst_cnt_r + 4'd1;
      end else begin
        burst_cnt_r  <= 4'd1;
        last_grant_r <= chosen_s;
      end
    end else if (out_valid_r && out_ready) begin
      out_valid_r <= 1'b0;
      burst_cnt_r <= 4'd0;
    end
  end

  assign {mux_sel_2, mux_sel_1, mux_sel_0} = sel_s;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_port  = out_port_r;

endmodule
